// File: rtl/apbbus_tmo.sv
`default_nettype none
// ============================================================================
//  Module   : apbbus_tmo
//  Purpose  : APB 1-to-N interconnect. It decodes the slave select field,
//             returns an error for unmapped accesses, aborts hung slaves with
//             a per-transfer timeout and keeps a sticky record of timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module apbbus_tmo #(
  parameter int          N        = 4,
  parameter int          DEC_LSB  = 16,
  parameter int          DEC_W    = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic              clk,
  input  logic              rst,
  // upstream (master side)
  input  logic              up_pwrite,
  input  logic [31:0]       up_pwdata,
  input  logic [31:0]       up_paddr,
  input  logic              up_penable,
  input  logic              up_psel,
  output logic              up_pready,
  output logic [31:0]       up_prdata,
  output logic              up_pslverr,
  // downstream (slave side)
  output logic              down_pwrite,
  output logic [31:0]       down_pwdata,
  output logic [31:0]       down_paddr,
  output logic              down_penable,
  output logic [N-1:0]      down_psel_vec,
  input  logic [N-1:0]      down_pready_vec,
  input  logic [N*32-1:0]   down_prdata_vec,
  input  logic [N-1:0]      down_pslverr_vec,
  // sticky timeout capture
  output logic              err_valid,
  output logic [31:0]       err_addr,
  output logic [7:0]        err_count,
  input  logic              err_clr
);

  // Counter only ever reaches TIMEOUT, so this width never wraps.
  localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam bit               TMO_EN  = (TIMEOUT != 0);
  localparam logic [DEC_W:0]   N_EXT   = (DEC_W + 1)'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [DEC_W-1:0]   idx;
  logic               mapped;
  logic               sel_pready;
  logic               sel_pslverr;
  logic [31:0]        sel_prdata;
  logic               abort_now;
  logic               abort_entry;

  assign idx    = up_paddr[DEC_LSB +: DEC_W];
  assign mapped = ({1'b0, idx} < N_EXT);

  // Request fields are broadcast unchanged to every slave.
  assign down_pwrite  = up_pwrite;
  assign down_pwdata  = up_pwdata;
  assign down_paddr   = up_paddr;
  assign down_penable = up_penable;

  // Reset wins over the registered state so outputs fall back to pass-through
  // in the very cycle rst is asserted.
  assign abort_now = (state == ABORT) && !rst;

  // Select the addressed slave's response; unmapped reads look ready.
  always_comb begin
    sel_pready  = 1'b1;
    sel_pslverr = 1'b0;
    sel_prdata  = ERR_DATA;
    for (int i = 0; i < N; i++) begin
      if (mapped && (idx == DEC_W'(i))) begin
        sel_pready  = down_pready_vec[i];
        sel_pslverr = down_pslverr_vec[i];
        sel_prdata  = down_prdata_vec[i*32 +: 32];
      end
    end
  end

  // One-hot slave select, suppressed while a timed-out transfer is aborted.
  always_comb begin
    down_psel_vec = '0;
    for (int i = 0; i < N; i++) begin
      down_psel_vec[i] = up_psel && mapped && !abort_now && (idx == DEC_W'(i));
    end
  end

  // Master-side response: abort, idle, decode error, or slave pass-through.
  always_comb begin
    up_pready  = sel_pready;
    up_pslverr = sel_pslverr;
    up_prdata  = sel_prdata;
    if (abort_now) begin
      up_pready  = 1'b1;
      up_pslverr = 1'b1;
      up_prdata  = ERR_DATA;
    end else if (!up_psel) begin
      up_pready  = 1'b1;
      up_pslverr = 1'b0;
      up_prdata  = ERR_DATA;
    end else if (!mapped) begin
      up_pready  = 1'b1;
      up_pslverr = up_penable;
      up_prdata  = ERR_DATA;
    end
  end

  // Timeout FSM: the counter holds the number of access cycles already
  // spent waiting, so ABORT lands on access cycle TIMEOUT+1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (TMO_EN && up_psel && up_penable && mapped && !sel_pready) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = (TIMEOUT == 1) ? ABORT : WAIT;
        end
      end
      WAIT: begin
        if (!up_psel || sel_pready) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == TMO_CNT) begin
            state_nxt = ABORT;
          end
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign abort_entry = (state_nxt == ABORT) && (state != ABORT);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sticky error capture; a new timeout overrides a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (abort_entry) begin
      err_valid <= 1'b1;
      if (!err_valid || err_clr) begin
        err_addr <= up_paddr;
      end
      if (err_clr) begin
        err_count <= 8'd1;
      end else if (err_count != 8'hff) begin
        err_count <= err_count + 8'd1;
      end
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apbbus_tmo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apbbus_tmo
//  Purpose  : Self-checking bench for apbbus_tmo (N=4, TIMEOUT=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_apbbus_tmo;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              up_pwrite, up_penable, up_psel;
  logic [31:0]       up_pwdata, up_paddr;
  logic              up_pready, up_pslverr;
  logic [31:0]       up_prdata;
  logic              down_pwrite, down_penable;
  logic [31:0]       down_pwdata, down_paddr;
  logic [N-1:0]      down_psel_vec, down_pready_vec, down_pslverr_vec;
  logic [N*32-1:0]   down_prdata_vec;
  logic              err_valid, err_clr;
  logic [31:0]       err_addr;
  logic [7:0]        err_count;

  int errors = 0;
  int checks = 0;

  apbbus_tmo #(
    .N(N), .DEC_LSB(16), .DEC_W(4), .TIMEOUT(8), .ERR_DATA(32'hdeadbeef)
  ) dut (
    .clk(clk), .rst(rst),
    .up_pwrite(up_pwrite), .up_pwdata(up_pwdata), .up_paddr(up_paddr),
    .up_penable(up_penable), .up_psel(up_psel),
    .up_pready(up_pready), .up_prdata(up_prdata), .up_pslverr(up_pslverr),
    .down_pwrite(down_pwrite), .down_pwdata(down_pwdata), .down_paddr(down_paddr),
    .down_penable(down_penable), .down_psel_vec(down_psel_vec),
    .down_pready_vec(down_pready_vec), .down_prdata_vec(down_prdata_vec),
    .down_pslverr_vec(down_pslverr_vec),
    .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        psel;
    logic        pen;
    logic        pwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rdy;
    logic [3:0]  serr;
    logic [3:0]  e_sel;
    logic        e_rdy;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[10];

  // One full timeout: setup, 8 waiting access cycles, then the abort cycle.
  task automatic run_timeout(input logic [31:0] addr, input logic clr_at_entry,
                             input logic [3:0] exp_sel);
    up_psel = 1'b1; up_penable = 1'b0; up_pwrite = 1'b0; up_paddr = addr;
    down_pready_vec = 4'b0000; down_pslverr_vec = 4'b0000;
    @(negedge clk);
    chk("tmo_setup_sel", {60'd0, down_psel_vec}, {60'd0, exp_sel});
    next_cycle();
    up_penable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) err_clr = clr_at_entry;
      @(negedge clk);
      chk("tmo_wait_sel_rdy", {59'd0, down_psel_vec, up_pready}, {59'd0, exp_sel, 1'b0});
      next_cycle();
    end
    err_clr = 1'b0;
    down_pready_vec = exp_sel;  // late ready in the abort cycle must be ignored
    @(negedge clk);
    chk("tmo_abort_sel", {60'd0, down_psel_vec}, 64'd0);
    chk("tmo_abort_rsp", {30'd0, up_pready, up_pslverr, up_prdata}, {30'd0, 1'b1, 1'b1, 32'hdeadbeef});
    next_cycle();
    up_psel = 1'b0; up_penable = 1'b0; down_pready_vec = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    up_pwrite = 1'b0; up_pwdata = '0; up_paddr = '0; up_penable = 1'b0; up_psel = 1'b0;
    down_pready_vec = '0; down_pslverr_vec = '0;
    down_prdata_vec = {32'hA3333333, 32'hA2222222, 32'h12345678, 32'hA0000000};

    //          psel pen  wr   addr           wdata          rdy     serr    e_sel   e_rdy e_err e_data
    vecs[0] = '{1'b0,1'b0,1'b0,32'h0000_0000,32'h0,         4'b0000,4'b0000,4'b0000,1'b1,1'b0,32'hdeadbeef};
    vecs[1] = '{1'b1,1'b0,1'b1,32'h0002_0010,32'hCAFE_0001, 4'b0100,4'b0000,4'b0100,1'b1,1'b0,32'hA2222222};
    vecs[2] = '{1'b1,1'b1,1'b1,32'h0002_0010,32'hCAFE_0001, 4'b0100,4'b0000,4'b0100,1'b1,1'b0,32'hA2222222};
    vecs[3] = '{1'b1,1'b0,1'b0,32'h0005_0000,32'h0,         4'b0000,4'b0000,4'b0000,1'b1,1'b0,32'hdeadbeef};
    vecs[4] = '{1'b1,1'b1,1'b0,32'h0005_0000,32'h0,         4'b0000,4'b0000,4'b0000,1'b1,1'b1,32'hdeadbeef};
    vecs[5] = '{1'b1,1'b1,1'b0,32'h0003_0000,32'h0,         4'b1000,4'b1000,4'b1000,1'b1,1'b1,32'hA3333333};
    vecs[6] = '{1'b1,1'b1,1'b0,32'h0000_FFFC,32'h0,         4'b0001,4'b0000,4'b0001,1'b1,1'b0,32'hA0000000};
    vecs[7] = '{1'b1,1'b1,1'b1,32'hFFF4_0000,32'h5555_AAAA, 4'b1111,4'b0000,4'b0000,1'b1,1'b1,32'hdeadbeef};
    vecs[8] = '{1'b1,1'b0,1'b0,32'h0001_0000,32'h0,         4'b0000,4'b0000,4'b0010,1'b0,1'b0,32'h12345678};
    vecs[9] = '{1'b1,1'b0,1'b1,32'h0002_0000,32'h0000_0077, 4'b1011,4'b0100,4'b0100,1'b0,1'b1,32'hA2222222};

    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_err", {23'd0, err_valid, err_count, err_addr}, 64'd0);
    chk("reset_idle_rsp", {30'd0, up_pready, up_pslverr, up_prdata}, {30'd0, 1'b1, 1'b0, 32'hdeadbeef});

    // Single-cycle combinational vectors (none of them start a wait).
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      up_psel = vecs[i].psel; up_penable = vecs[i].pen; up_pwrite = vecs[i].pwrite;
      up_paddr = vecs[i].addr; up_pwdata = vecs[i].wdata;
      down_pready_vec = vecs[i].rdy; down_pslverr_vec = vecs[i].serr;
      @(negedge clk);
      chk($sformatf("vec%0d_sel", i), {60'd0, down_psel_vec}, {60'd0, vecs[i].e_sel});
      chk($sformatf("vec%0d_rsp", i), {30'd0, up_pready, up_pslverr, up_prdata},
          {30'd0, vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_data});
      chk($sformatf("vec%0d_bcast", i), {down_pwrite, down_penable, down_pwdata, down_paddr[29:0]},
          {vecs[i].pwrite, vecs[i].pen, vecs[i].wdata, vecs[i].addr[29:0]});
    end
    next_cycle();
    up_psel = 1'b0; up_penable = 1'b0; down_pready_vec = '0; down_pslverr_vec = '0;

    // Read slave 1 with three wait states.
    next_cycle();
    up_psel = 1'b1; up_penable = 1'b0; up_pwrite = 1'b0; up_paddr = 32'h0001_0000;
    next_cycle();
    up_penable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("ws_wait_rdy", {63'd0, up_pready}, 64'd0);
      next_cycle();
    end
    down_pready_vec = 4'b0010;
    @(negedge clk);
    chk("ws_done_rsp", {30'd0, up_pready, up_pslverr, up_prdata}, {30'd0, 1'b1, 1'b0, 32'h12345678});
    next_cycle();
    up_psel = 1'b0; up_penable = 1'b0; down_pready_vec = '0;
    @(negedge clk);
    chk("ws_no_err", {63'd0, err_valid}, 64'd0);

    // First timeout captures its address.
    next_cycle();
    run_timeout(32'h0000_0004, 1'b0, 4'b0001);
    @(negedge clk);
    chk("tmo1_err", {23'd0, err_valid, err_count, err_addr}, {23'd0, 1'b1, 8'd1, 32'h0000_0004});

    // Second timeout: first address is kept, count goes to 2.
    next_cycle();
    run_timeout(32'h0001_0008, 1'b0, 4'b0010);
    @(negedge clk);
    chk("tmo2_err", {23'd0, err_valid, err_count, err_addr}, {23'd0, 1'b1, 8'd2, 32'h0000_0004});

    // Third timeout coinciding with err_clr: new error wins.
    next_cycle();
    run_timeout(32'h0003_000C, 1'b1, 4'b1000);
    @(negedge clk);
    chk("tmo3_clr_err", {23'd0, err_valid, err_count, err_addr}, {23'd0, 1'b1, 8'd1, 32'h0003_000C});

    // Reset in the fourth WAIT cycle.
    next_cycle();
    up_psel = 1'b1; up_penable = 1'b0; up_paddr = 32'h0000_0000; down_pready_vec = '0;
    next_cycle();
    up_penable = 1'b1;          // access 1: IDLE -> WAIT
    next_cycle();               // WAIT 1
    next_cycle();               // WAIT 2
    next_cycle();               // WAIT 3
    next_cycle();               // WAIT 4
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_passthru", {59'd0, down_psel_vec, up_pready}, {59'd0, 4'b0001, 1'b0});
    next_cycle();
    rst = 1'b0; up_psel = 1'b0; up_penable = 1'b0;
    @(negedge clk);
    chk("rst_wait_err", {23'd0, err_valid, err_count, err_addr}, 64'd0);
    chk("rst_wait_idle_rdy", {63'd0, up_pready}, 64'd1);

    // Fresh full-length timeout after reset, then a plain clear.
    next_cycle();
    run_timeout(32'h0000_0010, 1'b0, 4'b0001);
    @(negedge clk);
    chk("tmo4_err", {23'd0, err_valid, err_count, err_addr}, {23'd0, 1'b1, 8'd1, 32'h0000_0010});
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err", {23'd0, err_valid, err_count, err_addr}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
